seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1: operands a and b are valid.
REQ-005 The block SHALL have port in_ready, output, 1: block can accept operands this cycle.
REQ-006 The block SHALL have ports a and b, input, WIDTH each: multiplicand and multiplier.
REQ-007 The block SHALL have port signed_mode, input, 1, present only with SEQ_MULT_SIGNED_EN: operands are two's complement; sampled on accept.
REQ-008 The block SHALL have port out_valid, output, 1: product is valid.
REQ-009 The block SHALL have port out_ready, input, 1: consumer takes the product.
REQ-010 The block SHALL have port product, output, 2*WIDTH: result of a*b.
REQ-011 The block SHALL have port busy, output, 1: high while in the CALC state.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 An accept SHALL occur when in_valid and in_ready are both high at a rising edge.
REQ-014 On accept, the block SHALL latch a, b (and signed_mode), clear the accumulator, load the bit counter with WIDTH and move to CALC.
REQ-015 Each CALC cycle SHALL examine one multiplier bit, LSB first; if the bit is 1, the block SHALL add the shifted multiplicand to the accumulator and then decrement the counter.
REQ-016 Accumulator arithmetic SHALL be 2*WIDTH bits wide and no overflow SHALL be possible.
REQ-017 When the counter reaches 0, the block SHALL move to DONE; out_valid SHALL rise exactly WIDTH cycles after the accept edge.
REQ-018 In DONE, product and out_valid SHALL be held stable until out_ready is high.
REQ-019 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready), allowing back-to-back operations with no bubble.
REQ-020 If out_ready is high in DONE with no new accept, the block SHALL return to IDLE and out_valid SHALL fall on the next edge.
REQ-021 in_valid SHALL be ignored during CALC; latched operands SHALL be immune to input changes after accept.
REQ-022 The block SHALL keep product at its last value after a handshake until the next result is written.
REQ-023 A multiplier value of 0 SHALL still take WIDTH cycles; there SHALL be no early termination.

Reset
REQ-024 While rst is high at a clock edge, the block SHALL go to IDLE with product=0, out_valid=0, busy=0, accumulator and counter cleared; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-025 A reset during CALC or DONE SHALL abort the operation with no result emitted.

Configuration
REQ-026 With SEQ_MULT_SIGNED_EN defined, the block SHALL provide port signed_mode and handle signed operation as follows: when signed_mode=1, it SHALL multiply operand magnitudes and apply two's complement negation to the result when the operand signs differ.
REQ-027 With SEQ_MULT_SIGNED_EN defined, the negation SHALL be folded into the final CALC cycle so latency stays WIDTH.
REQ-028 Without SEQ_MULT_SIGNED_EN, the block SHALL have no signed_mode port and SHALL perform unsigned operation only, with identical timing.

Structure
REQ-029 Package seq_mult_pkg SHALL hold the state enumeration (IDLE, CALC, DONE) and the default-width constant.
REQ-030 The block SHALL be a single module with no sub-module, since the datapath (accumulator, shifter, counter) is too small to split.

Verification
REQ-031 With WIDTH=8, accepting a=13, b=11 SHALL give product=143 and out_valid rising 8 cycles after accept.
REQ-032 With WIDTH=8, a=255, b=255 SHALL give product=65025; a=0, b=200 SHALL give product=0 after 8 cycles.
REQ-033 With SEQ_MULT_SIGNED_EN, signed_mode=1, a=-3, b=5 SHALL give product=16'hFFF1, and a=-128, b=-128 SHALL give product=16'h4000.
REQ-034 With out_ready held low for 5 cycles in DONE, product and out_valid SHALL stay stable; when out_ready rises with in_valid high and a=2, b=3, the next product SHALL be 6 with no idle cycle between operations.
REQ-035 Asserting rst at CALC cycle 4 SHALL give IDLE, product=0, out_valid=0 next cycle, and a new operation 7*9 SHALL return 63.
REQ-036 With WIDTH=16, a=16'hFFFF, b=16'h0002 SHALL give product=32'h0001FFFE after 16 cycles.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared definitions for the sequential shift-and-add multiplier.
//   state_t                : controller states (IDLE, CALC, DONE)
//   SEQ_MULT_DEFAULT_WIDTH : default operand width in bits
package seq_mult_pkg;

  localparam int unsigned SEQ_MULT_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-and-add multiplier, one multiplier bit per
// cycle (LSB first). The result appears exactly WIDTH cycles after accept and
// is held until the consumer takes it. A new operand pair can be accepted in
// the same cycle the previous result is consumed.
//
// Optional feature macro: SEQ_MULT_SIGNED_EN
//   When defined, adds port signed_mode. With signed_mode=1 the operands are
//   two's complement; magnitudes are multiplied and the result is negated in
//   the final CALC cycle, so latency is unchanged.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   operands a/b valid
//   in_ready    out  block accepts operands this cycle
//   a, b        in   [WIDTH-1:0] multiplicand / multiplier
//   signed_mode in   (SEQ_MULT_SIGNED_EN only) two's complement operands
//   out_valid   out  product valid (state DONE)
//   out_ready   in   consumer takes the product
//   product     out  [2*WIDTH-1:0] result, held until the next result is written
//   busy        out  high while in CALC
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MULT_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state_q,   state_d;
  logic [PW-1:0]    mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [PW-1:0]    acc_q,     acc_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             neg_q,     neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic             sign_en;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic [PW-1:0]    acc_sum;

`ifdef SEQ_MULT_SIGNED_EN
  assign sign_en = signed_mode;
`else
  assign sign_en = 1'b0;
`endif

  // Magnitudes: the most negative value maps to 2^(WIDTH-1), which still
  // fits as an unsigned WIDTH-bit number, so no extra bit is needed.
  assign a_neg = sign_en & a[WIDTH-1];
  assign b_neg = sign_en & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

  // Partial-product add for the current multiplier bit.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    if (accept) begin
      // Accept is only possible from IDLE or from DONE while the result is taken.
      state_d  = CALC;
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
      neg_d    = a_neg ^ b_neg;
    end else begin
      unique case (state_q)
        IDLE: ;
        CALC: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Last bit: the sign fix is applied to the final sum here so the
            // result is ready at the same edge that enters DONE.
            state_d   = DONE;
            product_d = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed bench for seq_multiplier (WIDTH=8 and WIDTH=16).
// A transaction-level model predicts out_valid/busy/in_ready/product of the
// 8-bit instance every cycle; directed vectors add hand-computed literals.
`timescale 1ns/1ps
module tb_seq_multiplier;

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic SIGNED_BUILD = 1'b1;
`else
  localparam logic SIGNED_BUILD = 1'b0;
`endif

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy, sm;
  logic [7:0]  a, b;
  logic [15:0] product;

  logic        iv16, ir16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] product16;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  seq_multiplier #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(sm),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  seq_multiplier #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .out_valid(ov16), .out_ready(or16), .product(product16), .busy(busy16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product by plain arithmetic on sign/zero-extended operands.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [15:0] xe, ye;
    xe = s ? {{8{x[7]}}, x} : {8'h00, x};
    ye = s ? {{8{y[7]}}, y} : {8'h00, y};
    return xe * ye;
  endfunction

  // Transaction model: a result appears WIDTH cycles after accept and is
  // held until taken.
  logic [4:0]  m_cnt;
  logic        m_valid;
  logic [15:0] m_prod, m_pend;
  logic        m_in_ready;
  assign m_in_ready = (m_cnt == 5'd0) && (!m_valid || out_ready);

  always @(posedge clk) begin
    if (rst) begin
      m_cnt   <= 5'd0;
      m_valid <= 1'b0;
      m_prod  <= 16'h0;
    end else if (m_cnt != 5'd0) begin
      m_cnt <= m_cnt - 5'd1;
      if (m_cnt == 5'd1) begin
        m_valid <= 1'b1;
        m_prod  <= m_pend;
      end
    end else if (in_valid && m_in_ready) begin
      m_cnt   <= 5'(W);
      m_valid <= 1'b0;
      m_pend  <= ref_mul(a, b, sm & SIGNED_BUILD);
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model out_valid", 32'(out_valid), 32'(m_valid));
      check("model busy",      32'(busy),      32'(m_cnt != 5'd0));
      check("model in_ready",  32'(in_ready),  32'(m_in_ready));
      check("model product",   32'(product),   32'(m_prod));
    end
  end

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // One operation from IDLE; operands are scrambled during CALC to show
  // that the latched copies are used.
  task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input logic [15:0] exp);
    int k;
    a = x; b = y; sm = s; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'($urandom); b = 8'($urandom); sm = ~s;
    wait_valid(k);
    in_valid = 1'b0;
    check({name, " latency"}, 32'(k), 32'd8);
    check({name, " product"}, 32'(product), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sm = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset product",   32'(product),   32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset product16", product16,      32'd0);
    rst = 1'b0;
    check("in_ready after reset", 32'(in_ready), 32'd1);

    run_op("13*11",   8'd13,  8'd11,  1'b0, 16'd143);
    run_op("255*255", 8'd255, 8'd255, 1'b0, 16'd65025);
    run_op("0*200",   8'd0,   8'd200, 1'b0, 16'd0);

    // Result held under back-pressure, then back-to-back accept.
    a = 8'd5; b = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(k);
    check("stall latency", 32'(k), 32'd8);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall product",   32'(product),   32'd35);
      check("stall out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd2; b = 8'd3;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b busy",      32'(busy),      32'd1);
    check("b2b out_valid", 32'(out_valid), 32'd0);
    check("b2b old product held", 32'(product), 32'd35);
    wait_valid(k);
    check("2*3 latency", 32'(k), 32'd8);
    check("2*3 product", 32'(product), 32'd6);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("product kept after handshake", 32'(product), 32'd6);

    // Reset in the 4th CALC cycle aborts the operation.
    a = 8'd100; b = 8'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort product",   32'(product),   32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort busy",      32'(busy),      32'd0);
    rst = 1'b0;
    run_op("7*9", 8'd7, 8'd9, 1'b0, 16'd63);

`ifdef SEQ_MULT_SIGNED_EN
    run_op("s -3*5",       8'hFD, 8'h05, 1'b1, 16'hFFF1);
    run_op("s -128*-128",  8'h80, 8'h80, 1'b1, 16'h4000);
    run_op("s 7*-9",       8'h07, 8'hF7, 1'b1, 16'hFFC1);
    run_op("u-mode 253*5", 8'hFD, 8'h05, 1'b0, 16'd1265);
`endif

    // WIDTH=16 instance.
    check("w16 in_ready idle", 32'(ir16), 32'd1);
    a16 = 16'hFFFF; b16 = 16'h0002; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
    check("w16 busy", 32'(busy16), 32'd1);
    k = 0;
    while (!ov16 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("w16 latency", 32'(k), 32'd16);
    check("w16 product", product16, 32'h0001FFFE);
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    check("w16 out_valid drop", 32'(ov16), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
